program_loader: RTL and testbench
=================================

# program_loader

Nibble-serial program writer for the TD4 16×8 instruction memory. It receives a program from the Tiny Tapeout input pins, assembles each 8-bit word from two 4-bit nibbles, and drives the memory write port addresses 0 to 15 in order. It holds the CPU halted while loading and releases it when the last word is written. It sits between the pin mux and the memory write port (address, opcode, immediate, write).

## Interface
Parameters:
- none; depth 16 and nibble width 4 come from the shared package.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- load_req  in  1  level input. A rising edge while IDLE or DONE starts a session. Low mid-session aborts the session.
- nib_in  in  4  program nibble from pins; must be stable from nib_stb rise until nib_stb fall.
- nib_stb  in  1  asynchronous pin strobe; each rising edge delivers one nibble.
- mem_addr  out  4  memory address being written.
- mem_opcode  out  4  low nibble of the word (opcode).
- mem_immediate  out  4  high nibble of the word (immediate).
- mem_write  out  1  one-cycle write enable to memory.
- mem_opcode_rd  in  4  memory combinational read-back, opcode. Used only with verify.
- mem_immediate_rd  in  4  memory combinational read-back, immediate. Used only with verify.
- cpu_halt  out  1  high while a session is active.
- busy  out  1  high in any state other than IDLE and DONE.
- done  out  1  high in DONE.
- verify_err  out  1  sticky read-back mismatch flag. Constant 0 without the macro.

## Operation
- States: IDLE, LO, HI, WRITE, VERIFY (macro only), DONE.
- IDLE / DONE + load_req rising edge → LO:
  - mem_addr ← 0
  - verify_err ← 0
  - cpu_halt ← 1
- LO + accepted strobe → HI; mem_opcode ← nib_in.
- HI + accepted strobe → WRITE; mem_immediate ← nib_in.
- WRITE:
  - mem_write = 1 for exactly this cycle.
  - With verify → VERIFY. Without verify → address step.
- VERIFY:
  - If {mem_immediate_rd, mem_opcode_rd} ≠ {mem_immediate, mem_opcode}, set verify_err (sticky).
  - Then → address step.
- Address step:
  - mem_addr ≠ 15: mem_addr ← mem_addr+1, → LO.
  - mem_addr = 15: → DONE, cpu_halt ← 0, mem_addr stays 15. No wrap.
- Accepted strobe = synchronized rising edge of nib_stb while in LO or HI. Edges in any other state are discarded and never queued.
- load_req low in LO, HI, WRITE or VERIFY:
  - → IDLE next cycle, cpu_halt ← 0, done = 0.
  - Words already written stay in memory.
  - A WRITE cycle in progress still completes its mem_write.
- load_req held high in DONE has no effect. A new session requires a low then high transition.
- Memory is never cleared by this block.

## Timing
- Reset values:
  - state IDLE
  - mem_addr, mem_opcode, mem_immediate = 0
  - mem_write, cpu_halt, busy, done, verify_err = 0
- nib_stb passes through a 2-FF synchronizer plus an edge register. Acceptance occurs 3 clk after the pin rise, and nib_in is sampled in that same cycle.
- nib_stb minimum high time and minimum low time: 3 clk each.
- load_req is synchronous to clk, and its edge is detected with one register. A rising edge seen in cycle n puts the FSM in LO at n+1.
- Word latency: second accepted nibble at cycle n → mem_write at n+1 → next LO at n+2 (n+3 with verify).
- rst asserted at any point returns everything to reset values on the next edge, including mid-WRITE. The pending write is dropped if rst and WRITE share a cycle.

## Configuration
- PROGRAM_LOADER_VERIFY_EN defined:
  - VERIFY state present.
  - Read-back compare one cycle after each write.
  - verify_err is live.
- Undefined:
  - No VERIFY state; WRITE goes directly to the address step.
  - Read-back ports ignored.
  - verify_err tied to 0.
  - Session is one cycle shorter per word.

## Structure
- Shared package td4_pkg:
  - loader state enum
  - MEM_DEPTH = 16, ADDR_W = 4, NIBBLE_W = 4
  - LAST_ADDR = 4'hF
- Sub-module sync_edge: 2-FF synchronizer plus rising-edge pulse, used for nib_stb. The load_req edge register stays inline.

## Test plan
- Reset, then load_req rise and 32 strobes with nibbles 1,0,2,0,…,F,0 (address 15's word is 0x00, since no address-derived nibble is defined for it) → 16 mem_write pulses at addresses 0..15 with words 0x01..0x0F, 0x00. Then done=1, cpu_halt=0, mem_addr=15.
- Strobes while IDLE and while DONE → no mem_write, state unchanged. A 33rd strobe after DONE is ignored.
- load_req dropped after word 5's first nibble → IDLE next cycle, cpu_halt=0, no further writes. Re-raising load_req restarts at address 0.
- rst asserted in WRITE cycle for address 7 → mem_write=0 that cycle, all outputs at reset values next cycle.
- With PROGRAM_LOADER_VERIFY_EN, memory model corrupting address 3 (read-back 0xFF, written 0x3C) → verify_err=1 from VERIFY of address 3 through DONE. verify_err clears on the next session start.
- Strobe pulse with nib_in changing 1 clk after the pin rise, held stable for the remaining 2 of its 3 high cycles → sampled value is the value present at acceptance (3 clk after the rise); test checks the sampled nibble matches.

Source files
------------

// File: rtl/td4_pkg.sv
// td4_pkg: shared TD4 sizing constants and the program loader state encoding.
package td4_pkg;
    localparam int MEM_DEPTH = 16;
    localparam int ADDR_W = 4;
    localparam int NIBBLE_W = 4;
    localparam logic [ADDR_W-1:0] LAST_ADDR = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_WRITE,
`ifdef PROGRAM_LOADER_VERIFY_EN
        ST_VERIFY,
`endif
        ST_DONE
    } loader_state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-FF synchronizer for an asynchronous pin plus a one-cycle rising-edge pulse.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);
    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= {sr[1:0], async_in};
    end

    assign pulse = sr[1] & ~sr[2];
endmodule

// File: rtl/program_loader.sv
// program_loader: nibble-serial writer for the TD4 16x8 instruction memory.
// Define PROGRAM_LOADER_VERIFY_EN to add a read-back VERIFY cycle after each write.
import td4_pkg::*;

module program_loader (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_req,
    input  logic [NIBBLE_W-1:0] nib_in,
    input  logic                nib_stb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [NIBBLE_W-1:0] mem_opcode,
    output logic [NIBBLE_W-1:0] mem_immediate,
    output logic                mem_write,
    input  logic [NIBBLE_W-1:0] mem_opcode_rd,
    input  logic [NIBBLE_W-1:0] mem_immediate_rd,
    output logic                cpu_halt,
    output logic                busy,
    output logic                done,
    output logic                verify_err
);
    loader_state_t state, state_next;
    logic ld_q, ld_rise, stb_pulse, idle_like, step_st;
    logic [2:0] last_state_unused_pad;

    sync_edge u_stb (
        .clk      (clk),
        .rst      (rst),
        .async_in (nib_stb),
        .pulse    (stb_pulse)
    );

    assign ld_rise   = load_req & ~ld_q;
    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign last_state_unused_pad = '0;
`ifdef PROGRAM_LOADER_VERIFY_EN
    assign step_st = (state == ST_VERIFY);
`else
    assign step_st = (state == ST_WRITE);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ld_q  <= 1'b0;
        end else begin
            state <= state_next;
            ld_q  <= load_req;
        end
    end

    // Abort on load_req low takes priority over every in-session transition.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: state_next = ld_rise ? ST_LO : state;
            ST_LO:            state_next = !load_req ? ST_IDLE : stb_pulse ? ST_HI : ST_LO;
            ST_HI:            state_next = !load_req ? ST_IDLE : stb_pulse ? ST_WRITE : ST_HI;
`ifdef PROGRAM_LOADER_VERIFY_EN
            ST_WRITE:         state_next = !load_req ? ST_IDLE : ST_VERIFY;
            ST_VERIFY:        state_next = !load_req ? ST_IDLE : (mem_addr == LAST_ADDR) ? ST_DONE : ST_LO;
`else
            ST_WRITE:         state_next = !load_req ? ST_IDLE : (mem_addr == LAST_ADDR) ? ST_DONE : ST_LO;
`endif
            default:          state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = !idle_like;
        cpu_halt  = !idle_like;
        done      = (state == ST_DONE);
        mem_write = (state == ST_WRITE) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr      <= '0;
            mem_opcode    <= '0;
            mem_immediate <= '0;
        end else begin
            if (idle_like && ld_rise) mem_addr <= '0;
            if (state == ST_LO && stb_pulse) mem_opcode <= nib_in;
            if (state == ST_HI && stb_pulse) mem_immediate <= nib_in;
            if (step_st && state_next == ST_LO) mem_addr <= mem_addr + 4'd1;
        end
    end

`ifdef PROGRAM_LOADER_VERIFY_EN
    always_ff @(posedge clk) begin
        if (rst) verify_err <= 1'b0;
        else if (idle_like && ld_rise) verify_err <= 1'b0;
        else if (state == ST_VERIFY && {mem_immediate_rd, mem_opcode_rd} != {mem_immediate, mem_opcode}) verify_err <= 1'b1;
    end
`else
    logic unused_rd;
    assign unused_rd  = ^{mem_opcode_rd, mem_immediate_rd, last_state_unused_pad};
    assign verify_err = 1'b0;
`endif
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader with a 16x8 memory model.
module tb_program_loader;
    logic clk = 1'b0;
    logic rst, load_req, nib_stb;
    logic [3:0] nib_in;
    logic [3:0] mem_addr, mem_opcode, mem_immediate, mem_opcode_rd, mem_immediate_rd;
    logic mem_write, cpu_halt, busy, done, verify_err;

    int checks = 0;
    int errors = 0;
    int n_wr = 0;
    int base;
    logic [3:0] log_addr [64];
    logic [7:0] log_word [64];
    logic [7:0] mem [16];
    bit corrupt3 = 1'b0;

    program_loader dut (
        .clk              (clk),
        .rst              (rst),
        .load_req         (load_req),
        .nib_in           (nib_in),
        .nib_stb          (nib_stb),
        .mem_addr         (mem_addr),
        .mem_opcode       (mem_opcode),
        .mem_immediate    (mem_immediate),
        .mem_write        (mem_write),
        .mem_opcode_rd    (mem_opcode_rd),
        .mem_immediate_rd (mem_immediate_rd),
        .cpu_halt         (cpu_halt),
        .busy             (busy),
        .done             (done),
        .verify_err       (verify_err)
    );

    always #5 clk = ~clk;

    assign mem_opcode_rd    = (corrupt3 && mem_addr == 4'd3) ? 4'hF : mem[mem_addr][3:0];
    assign mem_immediate_rd = (corrupt3 && mem_addr == 4'd3) ? 4'hF : mem[mem_addr][7:4];

    always @(posedge clk) begin
        if (mem_write && n_wr < 64) begin
            log_addr[n_wr] <= mem_addr;
            log_word[n_wr] <= {mem_immediate, mem_opcode};
            mem[mem_addr]  <= {mem_immediate, mem_opcode};
            n_wr <= n_wr + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] v);
        nib_in = v;
        nib_stb = 1'b1;
        repeat (3) tick();
        nib_stb = 1'b0;
        repeat (3) tick();
    endtask

    task automatic load_word(input logic [7:0] w);
        strobe(w[3:0]);
        strobe(w[7:4]);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick();
        checks++; if ({mem_addr, mem_opcode, mem_immediate} !== 12'h000) begin errors++; $display("FAIL reset_data: got %h want 000", {mem_addr, mem_opcode, mem_immediate}); end
        checks++; if ({mem_write, cpu_halt, busy, done, verify_err} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {mem_write, cpu_halt, busy, done, verify_err}); end
        rst = 1'b0;
        tick();
        checks++; if ({busy, cpu_halt, done} !== 3'b000) begin errors++; $display("FAIL reset_release: got %b want 000", {busy, cpu_halt, done}); end
    endtask

    task automatic test_idle_strobe;
        base = n_wr;
        strobe(4'h5);
        checks++; if (n_wr - base !== 0) begin errors++; $display("FAIL idle_strobe_writes: got %0d want 0", n_wr - base); end
        checks++; if ({busy, mem_opcode} !== 5'h00) begin errors++; $display("FAIL idle_strobe_state: got %h want 00", {busy, mem_opcode}); end
    endtask

    task automatic test_full_load;
        base = n_wr;
        load_req = 1'b1;
        tick();
        checks++; if ({busy, cpu_halt, done, mem_addr} !== 7'b110_0000) begin errors++; $display("FAIL start: got %b want 1100000", {busy, cpu_halt, done, mem_addr}); end
        for (int i = 0; i < 16; i++) load_word(i == 15 ? 8'h00 : 8'(i + 1));
        checks++; if ({done, cpu_halt, busy} !== 3'b100) begin errors++; $display("FAIL full_done_flags: got %b want 100", {done, cpu_halt, busy}); end
        checks++; if (mem_addr !== 4'hF) begin errors++; $display("FAIL full_addr: got %h want f", mem_addr); end
        checks++; if (n_wr - base !== 16) begin errors++; $display("FAIL full_write_count: got %0d want 16", n_wr - base); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({log_addr[base + i], log_word[base + i]} !== {4'(i), (i == 15 ? 8'h00 : 8'(i + 1))})
                begin errors++; $display("FAIL full_word%0d: got addr %h word %h want addr %h word %h", i, log_addr[base + i], log_word[base + i], 4'(i), (i == 15 ? 8'h00 : 8'(i + 1))); end
        end
    endtask

    task automatic test_done_strobe;
        base = n_wr;
        strobe(4'h7);
        repeat (3) tick();
        checks++; if (n_wr - base !== 0) begin errors++; $display("FAIL done_strobe_writes: got %0d want 0", n_wr - base); end
        checks++; if ({done, busy, mem_addr, mem_opcode} !== 10'b10_1111_0000) begin errors++; $display("FAIL done_strobe_state: got %b want 1011110000", {done, busy, mem_addr, mem_opcode}); end
    endtask

    task automatic test_abort;
        load_req = 1'b0;
        tick();
        load_req = 1'b1;
        tick();
        checks++; if ({busy, done, mem_addr} !== 6'b10_0000) begin errors++; $display("FAIL restart: got %b want 100000", {busy, done, mem_addr}); end
        base = n_wr;
        for (int k = 0; k < 5; k++) load_word(8'hC0 + 8'(k));
        strobe(4'h9);
        checks++; if ({busy, mem_addr, mem_opcode} !== 9'b1_0101_1001) begin errors++; $display("FAIL abort_pre: got %b want 101011001", {busy, mem_addr, mem_opcode}); end
        load_req = 1'b0;
        tick();
        checks++; if ({busy, cpu_halt, done} !== 3'b000) begin errors++; $display("FAIL abort_idle: got %b want 000", {busy, cpu_halt, done}); end
        strobe(4'h3);
        strobe(4'h4);
        checks++; if (n_wr - base !== 5) begin errors++; $display("FAIL abort_writes: got %0d want 5", n_wr - base); end
        load_req = 1'b1;
        tick();
        checks++; if ({cpu_halt, mem_addr} !== 5'b1_0000) begin errors++; $display("FAIL abort_restart: got %b want 10000", {cpu_halt, mem_addr}); end
        load_word(8'h5E);
        checks++; if ({log_addr[n_wr - 1], log_word[n_wr - 1], mem_addr} !== 16'h0_5E_1) begin errors++; $display("FAIL abort_rewrite: got %h want 05e1", {log_addr[n_wr - 1], log_word[n_wr - 1], mem_addr}); end
    endtask

    task automatic test_reset_in_write;
        for (int a = 1; a < 7; a++) load_word(8'h70 + 8'(a));
        strobe(4'h2);
        nib_in = 4'h8;
        nib_stb = 1'b1;
        repeat (3) tick();
        checks++; if ({mem_write, mem_addr} !== 5'b1_0111) begin errors++; $display("FAIL write7: got %b want 10111", {mem_write, mem_addr}); end
        base = n_wr;
        rst = 1'b1;
        load_req = 1'b0;
        #1;
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_write_drop: got %b want 0", mem_write); end
        tick();
        checks++; if ({mem_addr, mem_opcode, mem_immediate} !== 12'h000) begin errors++; $display("FAIL rst_mid_data: got %h want 000", {mem_addr, mem_opcode, mem_immediate}); end
        checks++; if ({cpu_halt, busy, done, verify_err} !== 4'b0) begin errors++; $display("FAIL rst_mid_flags: got %b want 0000", {cpu_halt, busy, done, verify_err}); end
        nib_stb = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        checks++; if ({n_wr - base, busy, mem_write} !== {32'd0, 2'b00}) begin errors++; $display("FAIL rst_mid_after: got writes %0d busy %b want 0 0", n_wr - base, busy); end
    endtask

    task automatic test_nib_change;
        load_req = 1'b1;
        tick();
        base = n_wr;
        nib_in = 4'h2;
        nib_stb = 1'b1;
        tick();
        nib_in = 4'hB;
        repeat (2) tick();
        nib_stb = 1'b0;
        checks++; if (mem_opcode !== 4'hB) begin errors++; $display("FAIL nib_change_lo: got %h want b", mem_opcode); end
        repeat (3) tick();
        nib_in = 4'h1;
        nib_stb = 1'b1;
        tick();
        nib_in = 4'h6;
        repeat (2) tick();
        nib_stb = 1'b0;
        repeat (3) tick();
        checks++; if (mem_immediate !== 4'h6) begin errors++; $display("FAIL nib_change_hi: got %h want 6", mem_immediate); end
        checks++; if ({n_wr - base, log_addr[n_wr - 1], log_word[n_wr - 1]} !== {32'd1, 4'h0, 8'h6B}) begin errors++; $display("FAIL nib_change_word: got n %0d addr %h word %h want 1 0 6b", n_wr - base, log_addr[n_wr - 1], log_word[n_wr - 1]); end
        load_req = 1'b0;
        tick();
    endtask

`ifdef PROGRAM_LOADER_VERIFY_EN
    task automatic test_verify;
        load_req = 1'b1;
        tick();
        corrupt3 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            load_word(i == 3 ? 8'h3C : 8'(i + 1));
            if (i == 2) begin checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL verify_before: got %b want 0", verify_err); end end
            if (i == 3) begin checks++; if (verify_err !== 1'b1) begin errors++; $display("FAIL verify_at3: got %b want 1", verify_err); end end
        end
        checks++; if ({done, verify_err} !== 2'b11) begin errors++; $display("FAIL verify_done: got %b want 11", {done, verify_err}); end
        load_req = 1'b0;
        tick();
        load_req = 1'b1;
        tick();
        checks++; if ({busy, verify_err} !== 2'b10) begin errors++; $display("FAIL verify_clear: got %b want 10", {busy, verify_err}); end
        load_req = 1'b0;
        corrupt3 = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        load_req = 1'b0;
        nib_stb = 1'b0;
        nib_in = 4'h0;
        test_reset();
        test_idle_strobe();
        test_full_load();
        test_done_strobe();
        test_abort();
        test_reset_in_write();
        test_nib_change();
`ifdef PROGRAM_LOADER_VERIFY_EN
        test_verify();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end
endmodule
